// File: rtl/div.sv
// Iterative 32-bit signed/unsigned divider: one restoring step per cycle,
// producing {remainder, quotient} 33 cycles after a request is accepted.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    // state  | meaning
    // FREE   | idle, waiting for start_i
    // BYZERO | divisor was zero, result is forced to 0
    // ON     | 32 restoring iterations in progress
    // END    | result valid, held until start_i drops
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] trial;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op1_mag  = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        op2_mag  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        trial    = {1'b0, dividend[63:32]} - {1'b0, divisor};
        quot     = dividend[31:0];
        rem      = dividend[64:33];
        quot_fix = neg_q ? (~quot + 32'd1) : quot;
        rem_fix  = neg_r ? (~rem + 32'd1) : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FREE;
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'h0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    result_o <= 64'h0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state    <= ST_ON;
                            cnt      <= 6'd0;
                            dividend <= {32'd0, op1_mag, 1'b0};
                            divisor  <= op2_mag;
                            // signs are latched from the raw operands, not the magnitudes
                            neg_q    <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r    <= signed_div_i && opdata1_i[31];
                        end
                    end
                end
                ST_BYZERO: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        result_o <= 64'h0;
                        ready_o  <= 1'b0;
                    end else begin
                        state    <= ST_END;
                        result_o <= 64'h0;
                        ready_o  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        cnt      <= 6'd0;
                        result_o <= 64'h0;
                        ready_o  <= 1'b0;
                    end else if (cnt == 6'd32) begin
                        state    <= ST_END;
                        cnt      <= 6'd0;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (trial[32])
                            dividend <= {dividend[63:0], 1'b0};
                        else
                            dividend <= {trial[31:0], dividend[31:0], 1'b1};
                    end
                end
                ST_END: begin
                    if (!start_i) begin
                        state    <= ST_FREE;
                        result_o <= 64'h0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_FREE;
                    result_o <= 64'h0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed-vector bench for the iterative divider: latency, results, zero
// divisor, annul, mid-division reset and result hold in END.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int pass_cnt  = 0;
    int check_cnt = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // counts edges after the current one until ready rises, bounded
    task automatic wait_ready(output int k);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (ready) break;
        end
    endtask

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [63:0] exp, input int hold);
        int k;
        @(negedge clk);
        signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1;
        @(posedge clk); #1;
        check("ready_at_accept", {63'd0, ready}, 64'd0);
        @(negedge clk);
        opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
        wait_ready(k);
        check("latency", 64'(k), 64'(lat));
        check("result", result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_ready", {63'd0, ready}, 64'd1);
            check("hold_result", result, exp);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", {63'd0, ready}, 64'd0);
        check("drop_result", result, 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        vecs[0] = '{1'b0, 32'd100,        32'd7,        33, {32'd2,        32'd14}};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        33, {32'hFFFFFFFF, 32'hFFFFFFFD}};
        vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 33, {32'd0,        32'h80000000}};
        vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        33, {32'd0,        32'hFFFFFFFF}};
        vecs[4] = '{1'b0, 32'd1234,       32'd0,        1,  64'd0};
        vecs[5] = '{1'b1, 32'hFFFFFFF9,   32'd0,        1,  64'd0};
        vecs[6] = '{1'b1, 32'd7,          32'hFFFFFFFE, 33, {32'd1,        32'hFFFFFFFD}};
        vecs[7] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 33, {32'hFFFFFFFF, 32'd3}};
        vecs[8] = '{1'b0, 32'hFFFFFFF9,   32'd2,        33, {32'd1,        32'h7FFFFFFC}};

        // reset held with a pending request: reset wins, request taken on first free edge
        rst = 1'b1; annul = 1'b0; start = 1'b1; signed_div = 1'b0;
        opdata1 = 32'd100; opdata2 = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_ready", {63'd0, ready}, 64'd0);
            check("reset_result", result, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        wait_ready(k);
        check("first_req_latency", 64'(k), 64'd33);
        check("first_req_result", result, {32'd2, 32'd14});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("first_req_drop", {63'd0, ready}, 64'd0);

        foreach (vecs[i])
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp, (i == 0) ? 5 : 1);

        // annul while iterating, ready must never rise
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            check("pre_annul_ready", {63'd0, ready}, 64'd0);
        end
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("annul_ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_annul_ready", {63'd0, ready}, 64'd0);
            check("post_annul_result", result, 64'd0);
        end
        do_div(1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1);

        // annul in the zero-divisor path
        @(negedge clk);
        opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("annul_byzero_ready", {63'd0, ready}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        @(posedge clk); #1;
        check("annul_byzero_idle", {63'd0, ready}, 64'd0);

        // reset mid-division, start held: division restarts from scratch
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_ready", {63'd0, ready}, 64'd0);
        check("midreset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        wait_ready(k);
        check("restart_latency", 64'(k), 64'd33);
        check("restart_result", result, {32'd2, 32'd14});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("restart_drop", {63'd0, ready}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
